// File: rtl/otf_converter_r4.sv
// otf_converter_r4: on-the-fly conversion of an MSD-first radix-4 signed-digit stream to two's complement
module otf_converter_r4 #(
    parameter int N = 8,
    localparam int QW = 2 * N + 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 en,
    input  logic signed [2:0]    zi,
    output logic        [QW-1:0] q,
    output logic                 q_valid,
    output logic                 busy,
    output logic                 digit_err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [QW-1:0] acc_q, acc_d, qm_q, qm_d, q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_valid_q, q_valid_d, err_q, err_d;
    logic          bad, pos, neg;
    logic [1:0]    lo, lom;
    logic [QW-1:0] nxt_acc, nxt_qm;

    always_comb begin
        bad     = zi == 3'sb100;
        neg     = zi[2] && !bad;
        pos     = !zi[2] && zi != 3'sd0;
        lo      = bad ? 2'd0 : zi[1:0];
        // low two bits of d-1 serve both the d>0 QM append and the d<=0 QM append
        lom     = lo - 2'd1;
        nxt_acc = {neg ? qm_q[QW-3:0] : acc_q[QW-3:0], lo};
        nxt_qm  = {pos ? acc_q[QW-3:0] : qm_q[QW-3:0], lom};
        state_d   = state_q;
        acc_d     = acc_q;
        qm_d      = qm_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        err_d     = err_q;
        if (start) begin
            state_d   = CONVERT;
            acc_d     = '0;
            qm_d      = '1;
            cnt_d     = '0;
            q_valid_d = 1'b0;
            err_d     = 1'b0;
        end else if (state_q == CONVERT && en) begin
            acc_d = nxt_acc;
            qm_d  = nxt_qm;
            cnt_d = cnt_q + 1'b1;
            err_d = err_q | bad;
            if (cnt_q == CW'(N - 1)) begin
                state_d   = DONE;
                q_d       = nxt_acc;
                q_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            qm_q      <= '1;
            cnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            qm_q      <= qm_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            err_q     <= err_d;
        end
    end

    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign busy      = state_q == CONVERT;
    assign digit_err = err_q;
endmodule

// File: tb/tb_otf_converter_r4.sv
// tb_otf_converter_r4: scoreboard bench for the radix-4 on-the-fly converter at N=4
module tb_otf_converter_r4;
    localparam int N = 4;
    localparam int QW = 2 * N + 1;
    localparam int GAP = 99;

    logic clk = 0, reset = 1, start = 0, en = 0;
    logic signed [2:0] zi = '0;
    logic [QW-1:0] q;
    logic q_valid, busy, digit_err;
    int n_cmp = 0, n_bad = 0;
    int stim[$];
    logic [QW-1:0] sb[$];

    otf_converter_r4 #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .en(en), .zi(zi),
        .q(q), .q_valid(q_valid), .busy(busy), .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic s, input logic e, input int d);
        start = s;
        en = e;
        zi = 3'(d);
        @(posedge clk);
        #1;
        start = 0;
        en = 0;
        zi = '0;
    endtask

    // Runs one conversion from stim (GAP = en low); model tracks Q as an integer, QM as Q-1.
    task automatic convert(input string nm, input logic start_en);
        int ev = 0, mq = 0, cnt = 0;
        logic [QW-1:0] prev_q, exp_q;
        foreach (stim[i]) if (stim[i] != GAP) ev = ev * 4 + (stim[i] == -4 ? 0 : stim[i]);
        sb.push_back(QW'(ev));
        prev_q = q;
        cyc(1, start_en, 3);
        n_cmp++; if (q_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL %s start: q_valid=%b busy=%b want 0/1", nm, q_valid, busy); end
        n_cmp++; if (q !== prev_q) begin n_bad++; $display("FAIL %s q_hold: q=%h want %h", nm, q, prev_q); end
        foreach (stim[i]) begin
            if (stim[i] == GAP) begin
                cyc(0, 0, 0);
            end else begin
                cyc(0, 1, stim[i]);
                mq = mq * 4 + (stim[i] == -4 ? 0 : stim[i]);
                cnt++;
                n_cmp++; if (dut.acc_q !== QW'(mq) || dut.qm_q !== QW'(mq - 1)) begin n_bad++; $display("FAIL %s step%0d: Q=%h QM=%h want %h %h", nm, cnt, dut.acc_q, dut.qm_q, QW'(mq), QW'(mq - 1)); end
            end
            if (cnt < N) begin
                n_cmp++; if (q_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL %s early: q_valid=%b busy=%b want 0/1", nm, q_valid, busy); end
            end
        end
        exp_q = sb.pop_front();
        n_cmp++; if (q_valid !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL %s done: q_valid=%b busy=%b want 1/0", nm, q_valid, busy); end
        n_cmp++; if (q !== exp_q) begin n_bad++; $display("FAIL %s result: q=%h want %h", nm, q, exp_q); end
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({q, q_valid, busy, digit_err} !== '0) begin n_bad++; $display("FAIL reset: q=%h qv=%b busy=%b err=%b want 0", q, q_valid, busy, digit_err); end
        n_cmp++; if (dut.qm_q !== '1) begin n_bad++; $display("FAIL reset_qm: QM=%h want 1ff", dut.qm_q); end
        reset = 0;
        cyc(0, 1, 3);
        n_cmp++; if (busy !== 1'b0 || dut.acc_q !== '0) begin n_bad++; $display("FAIL idle_en: busy=%b Q=%h want 0/0", busy, dut.acc_q); end
    endtask

    task automatic test_basic;
        stim = '{1, -2, 3, 0}; convert("basic", 0);
    endtask

    task automatic test_extremes;
        stim = '{3, 3, 3, 3}; convert("max", 0);
        stim = '{-3, -3, -3, -3}; convert("min", 0);
    endtask

    task automatic test_invariant;
        stim = '{0, 0, 0, -1}; convert("neg1a", 0);
        stim = '{-1, 3, 3, 3}; convert("neg1b", 0);
    endtask

    task automatic test_gaps;
        stim = '{2, GAP, GAP, -1, GAP, 1, 2}; convert("gaps", 0);
    endtask

    task automatic test_back_to_back;
        stim = '{1, 1, 1, 1}; convert("start_en", 1);
        cyc(0, 1, 2);
        n_cmp++; if (q !== 9'd85 || q_valid !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL after_done: q=%h qv=%b busy=%b want 055/1/0", q, q_valid, busy); end
    endtask

    task automatic test_abort;
        cyc(1, 0, 0); cyc(0, 1, 2); cyc(0, 1, 1);
        #2 reset = 1;
        #1;
        n_cmp++; if ({q, q_valid, busy, digit_err} !== '0) begin n_bad++; $display("FAIL async_reset: q=%h qv=%b busy=%b err=%b want 0", q, q_valid, busy, digit_err); end
        @(negedge clk) reset = 0;
        @(posedge clk); #1;
        stim = '{2, 2, 2, 2}; convert("pre_restart", 0);
        cyc(1, 0, 0); cyc(0, 1, 3); cyc(0, 1, -3);
        stim = '{0, 1, 0, 2}; convert("restart", 0);
        stim = '{1, -4, 2, 0}; convert("bad_digit", 0);
        n_cmp++; if (digit_err !== 1'b1) begin n_bad++; $display("FAIL digit_err_set: err=%b want 1", digit_err); end
        cyc(1, 0, 0);
        n_cmp++; if (digit_err !== 1'b0) begin n_bad++; $display("FAIL digit_err_clear: err=%b want 0", digit_err); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_invariant;
        test_gaps;
        test_back_to_back;
        test_abort;
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard: %0d left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
